// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: post-reset bubbles, load-use stall, branch flush, memory freeze with timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned INIT_BUBBLES = 4,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RSAddr_i,
    input  logic [4:0]       IF_ID_RTAddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_RTAddr_i,
    input  logic             Branch_i,
    input  logic             MemReq_i,
    input  logic             MemAck_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             ID_EX_Write_o,
    output logic             EX_MEM_Write_o,
    output logic             MEM_WB_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Flush_o,
    output logic [1:0]       State_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o,
    output logic [CNT_W-1:0] FreezeCnt_o
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    localparam logic [7:0] BUB_LAST  = 8'(INIT_BUBBLES - 1);
    localparam logic [9:0] WAIT_LAST = 10'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] bub_q, bub_d;
    logic [9:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;

    logic load_use;
    logic mem_stall;
    logic advance;
    logic hold;
    logic lu_fire;
    logic br_fire;

    always_comb begin
        load_use  = ID_EX_MemRead_i && (ID_EX_RTAddr_i != '0) &&
                    ((ID_EX_RTAddr_i == IF_ID_RSAddr_i) || (ID_EX_RTAddr_i == IF_ID_RTAddr_i));
        mem_stall = MemReq_i && !MemAck_i;
    end

    always_comb begin
        state_d        = state_q;
        bub_d          = bub_q;
        wait_d         = wait_q;
        timeout_d      = timeout_q;
        advance        = 1'b0;
        hold           = 1'b0;
        lu_fire        = 1'b0;
        br_fire        = 1'b0;
        PCWrite_o      = 1'b1;
        IF_ID_Write_o  = 1'b1;
        ID_EX_Write_o  = 1'b1;
        EX_MEM_Write_o = 1'b1;
        MEM_WB_Write_o = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Flush_o  = 1'b0;

        case (state_q)
            ST_INIT: begin
                PCWrite_o     = 1'b0;
                IF_ID_Flush_o = 1'b1;
                ID_EX_Flush_o = 1'b1;
                if (bub_q == BUB_LAST) begin
                    state_d = ST_RUN;
                    bub_d   = '0;
                end else begin
                    bub_d = bub_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (mem_stall) begin
                    hold    = 1'b1;
                    state_d = ST_FREEZE;
                    wait_d  = '0;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_FREEZE: begin
                // A timeout release behaves exactly like an ack, but is remembered.
                if (MemAck_i || (wait_q == WAIT_LAST)) begin
                    advance = 1'b1;
                    state_d = ST_RUN;
                    wait_d  = '0;
                    if (!MemAck_i) begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    hold   = 1'b1;
                    wait_d = wait_q + 10'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
                bub_d   = '0;
                wait_d  = '0;
            end
        endcase

        if (advance) begin
            lu_fire = load_use;
            br_fire = Branch_i && !load_use;
        end

        if (hold) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Write_o  = 1'b0;
            EX_MEM_Write_o = 1'b0;
            MEM_WB_Write_o = 1'b0;
        end
        if (lu_fire) begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Flush_o = 1'b1;
        end
        if (br_fire) begin
            IF_ID_Flush_o = 1'b1;
        end

        if (rst_i) begin
            hold           = 1'b0;
            lu_fire        = 1'b0;
            br_fire        = 1'b0;
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b1;
            ID_EX_Write_o  = 1'b1;
            EX_MEM_Write_o = 1'b1;
            MEM_WB_Write_o = 1'b1;
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Flush_o  = 1'b1;
            state_d        = ST_INIT;
            bub_d          = '0;
            wait_d         = '0;
            timeout_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_INIT;
            bub_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bub_q     <= bub_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign State_o   = rst_i ? ST_INIT : state_q;
    assign Timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (lu_fire && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (br_fire && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (hold && (freeze_cnt_q != '1)) begin
                freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCnt_o  = stall_cnt_q;
    assign FlushCnt_o  = flush_cnt_q;
    assign FreezeCnt_o = freeze_cnt_q;
`else
    assign StallCnt_o  = '0;
    assign FlushCnt_o  = '0;
    assign FreezeCnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model expectations, negedge monitor compares.
module tb_pipe_hazard_ctrl;

    localparam int unsigned INIT_B = 4;
    localparam int unsigned TMO    = 16;
    localparam int unsigned CW     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [4:0]    rs = '0, rt = '0, ex_rt = '0;
    logic          mr = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
    logic          pcw, ifidw, idexw, exmemw, memwbw, ifidf, idexf;
    logic [1:0]    st;
    logic          tmo;
    logic [CW-1:0] scnt, fcnt, zcnt;

    pipe_hazard_ctrl #(.INIT_BUBBLES(INIT_B), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RSAddr_i(rs), .IF_ID_RTAddr_i(rt),
        .ID_EX_MemRead_i(mr), .ID_EX_RTAddr_i(ex_rt),
        .Branch_i(br), .MemReq_i(req), .MemAck_i(ack),
        .PCWrite_o(pcw), .IF_ID_Write_o(ifidw), .ID_EX_Write_o(idexw),
        .EX_MEM_Write_o(exmemw), .MEM_WB_Write_o(memwbw),
        .IF_ID_Flush_o(ifidf), .ID_EX_Flush_o(idexf),
        .State_o(st), .Timeout_o(tmo),
        .StallCnt_o(scnt), .FlushCnt_o(fcnt), .FreezeCnt_o(zcnt)
    );

    typedef struct {
        logic [6:0]    ctl;
        logic [1:0]    st;
        logic          tmo;
        logic [CW-1:0] sc, fc, zc;
        bit            chk_regs;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done = 0;

    // Reference model: cycles of bubbles left, whether a memory wait is in progress and how long.
    int init_left = 0;
    bit frozen = 0;
    int waited = 0;
    bit m_tmo = 0;
    int n_stall = 0, n_flush = 0, n_freeze = 0;
    bit regs_known = 0;

    function automatic logic [CW-1:0] sat(input int n);
        int top;
        top = (1 << CW) - 1;
        return (n > top) ? CW'(top) : CW'(n);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic a_mr, input logic [4:0] a_ert, input logic a_br,
                       input logic a_req, input logic a_ack);
        exp_t e;
        bit lu, brf, rel, hold;
        @(posedge clk);
        #1;
        rst = r; rs = a_rs; rt = a_rt; mr = a_mr; ex_rt = a_ert;
        br = a_br; req = a_req; ack = a_ack;
        e.chk_regs = regs_known;
        e.tmo = m_tmo;
        e.sc  = sat(n_stall);
        e.fc  = sat(n_flush);
        e.zc  = sat(n_freeze);
        lu = 0; brf = 0; hold = 0;
        if (r || init_left > 0) begin
            e.ctl = 7'b0111111;
            e.st  = 2'd0;
        end else begin
            rel  = frozen && (a_ack || waited == int'(TMO) - 1);
            hold = frozen ? !rel : (a_req && !a_ack);
            e.st = frozen ? 2'd2 : 2'd1;
            if (hold) begin
                e.ctl = 7'b0000000;
            end else begin
                lu  = a_mr && a_ert != 0 && (a_ert == a_rs || a_ert == a_rt);
                brf = a_br && !lu;
                e.ctl = {!lu, !lu, 1'b1, 1'b1, 1'b1, brf, lu};
            end
        end
        q.push_back(e);

        if (r) begin
            init_left = INIT_B; frozen = 0; waited = 0; m_tmo = 0;
            n_stall = 0; n_flush = 0; n_freeze = 0; regs_known = 1;
        end else if (init_left > 0) begin
            init_left--;
        end else if (hold) begin
`ifdef HAZARD_PERF_CNT_EN
            n_freeze++;
`endif
            if (frozen) waited++;
            else begin frozen = 1; waited = 0; end
        end else begin
            if (frozen && !a_ack) m_tmo = 1;
            frozen = 0;
            waited = 0;
`ifdef HAZARD_PERF_CNT_EN
            if (lu) n_stall++;
            if (brf) n_flush++;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        while (!done || q.size() > 0) begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ctl{pcw,ifidw,idexw,exmemw,memwbw,ifidf,idexf}",
                      32'({pcw, ifidw, idexw, exmemw, memwbw, ifidf, idexf}), 32'(e.ctl));
                check("state", 32'(st), 32'(e.st));
                if (e.chk_regs) begin
                    check("timeout", 32'(tmo), 32'(e.tmo));
                    check("stall_cnt", 32'(scnt), 32'(e.sc));
                    check("flush_cnt", 32'(fcnt), 32'(e.fc));
                    check("freeze_cnt", 32'(zcnt), 32'(e.zc));
                end
            end
        end
    end

    initial begin
        int guard;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        // load-use on RS, on RT, and EX RT=0 (no stall)
        cyc(0, 5, 1, 1, 5, 0, 0, 0);
        cyc(0, 2, 7, 1, 7, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 3, 4, 1, 6, 0, 0, 0);
        // load-use together with branch, then branch alone
        cyc(0, 5, 1, 1, 5, 1, 0, 0);
        cyc(0, 5, 1, 0, 5, 1, 0, 0);
        idle(2);
        // memory ack arriving on the fourth request cycle
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 5, 1, 1, 5, 1, 1, 1);
        idle(2);
        // 20 consecutive load-use stalls saturate a 4-bit counter
        for (int i = 0; i < 20; i++) cyc(0, 9, 2, 1, 9, 1, 0, 0);
        idle(2);
        // reset in the middle of a freeze must not flag timeout
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        idle(8);
        // no ack: forced release and sticky timeout
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        cyc(0, 4, 0, 1, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 3));
        end
        idle(2);
        done = 1;
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
